// File: rtl/score_display_pkg.sv
// Shared types and seven-segment codes for the score display datapath.
// Segment bit order is seg[6:0], active high.
package score_display_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } dd_state_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h03;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h67;
  localparam logic [6:0] SEG_4     = 7'h53;
  localparam logic [6:0] SEG_5     = 7'h76;
  localparam logic [6:0] SEG_6     = 7'h7E;
  localparam logic [6:0] SEG_7     = 7'h23;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h77;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_ERR   = 7'h78;

  // Double-dabble correction applied to each nibble before the left shift.
  function automatic bcd_t dd_adjust(input bcd_t n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/seg7_digit_lut.sv
// Combinational BCD digit to seven-segment code; non-decimal codes show
// the error pattern.
module seg7_digit_lut
  import score_display_pkg::*;
(
  input  bcd_t       digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_ERR;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_ERR;
    endcase
  end

endmodule

// File: rtl/score_display.sv
// Binary score to multiplexed seven-segment display: serial double-dabble
// conversion, atomic display update, leading-zero blanking and over-range.
module score_display
  import score_display_pkg::*;
#(
  parameter int SCORE_W  = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 1024,
  parameter int BLANK_LZ = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SCORE_W-1:0] score,
  input  logic               load,
  output logic               busy,
  output logic [6:0]         seg,
  output logic [DIGITS-1:0]  dig_en
);

  localparam int NIB   = DIGITS + 1;
  localparam int BCD_W = 4 * NIB;
  localparam int CNT_W = $clog2(SCORE_W);
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  dd_state_t            state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg;
  logic [SCORE_W-1:0]   bin_reg;
  logic [BCD_W-1:0]     bcd_reg;
  logic                 ovf_reg;
  logic                 ld_accept, commit;

  logic [SCORE_W-1:0]   step_bin_in, step_bin;
  logic [BCD_W-1:0]     step_bcd_in, bcd_adj, step_bcd;
  logic                 step_ovf_in, step_carry;

  logic [4*DIGITS-1:0]  disp_reg;
  logic                 disp_ovf_reg;

  logic [PRE_W-1:0]     presc_reg, presc_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic                 terminal;
  logic [6:0]           digit_code [DIGITS];
  logic [DIGITS:1]      lz;
  logic [6:0]           seg_reg;
  logic [DIGITS-1:0]    dig_en_reg;

  // The first iteration runs on the accepting edge straight from the score
  // input, so the whole conversion fits inside SCORE_W busy cycles.
  always_comb begin
    step_bin_in = bin_reg;
    step_bcd_in = bcd_reg;
    step_ovf_in = ovf_reg;
    if (state_reg == ST_IDLE) begin
      step_bin_in = score;
      step_bcd_in = '0;
      step_ovf_in = 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NIB; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = dd_adjust(step_bcd_in[gi*4 +: 4]);
    end
  endgenerate

  // A bit leaving the top nibble means the value overflowed the accumulator.
  assign {step_carry, step_bcd, step_bin} = {bcd_adj, step_bin_in, 1'b0};

  always_comb begin
    state_next = state_reg;
    ld_accept  = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (load) begin
          ld_accept  = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_reg == CNT_W'(SCORE_W - 2)) state_next = ST_DONE;
      end
      ST_DONE: begin
        commit     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      bin_reg   <= '0;
      bcd_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (ld_accept || state_reg == ST_SHIFT) begin
        bin_reg <= step_bin;
        bcd_reg <= step_bcd;
        ovf_reg <= step_ovf_in | step_carry;
      end
      if (ld_accept) cnt_reg <= '0;
      else if (state_reg == ST_SHIFT) cnt_reg <= cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_reg     <= '0;
      disp_ovf_reg <= 1'b0;
    end else if (commit) begin
      disp_reg     <= bcd_reg[4*DIGITS-1:0];
      disp_ovf_reg <= ovf_reg | (bcd_reg[BCD_W-1 -: 4] != 4'd0);
    end
  end

  assign terminal   = (presc_reg == PRE_W'(SCAN_DIV - 1));
  assign presc_next = terminal ? '0 : presc_reg + 1'b1;

  always_comb begin
    idx_next = idx_reg;
    if (terminal) begin
      if (idx_reg == IDX_W'(DIGITS - 1)) idx_next = '0;
      else idx_next = idx_reg + 1'b1;
    end
  end

  // lz[k]: digit k and every digit above it are zero.
  assign lz[DIGITS] = 1'b1;

  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [6:0] lut_seg;
      logic       blank;

      seg7_digit_lut u_lut (
        .digit (disp_reg[gi*4 +: 4]),
        .seg   (lut_seg)
      );

      if (gi == 0) begin : g_units
        assign blank = 1'b0;
      end else begin : g_upper
        assign lz[gi] = (disp_reg[gi*4 +: 4] == 4'd0) && lz[gi+1];
        assign blank  = (BLANK_LZ != 0) && lz[gi];
      end

      assign digit_code[gi] = disp_ovf_reg ? SEG_ERR :
                              (blank ? SEG_BLANK : lut_seg);
    end
  endgenerate

  // seg and dig_en are loaded from the same next index so they never skew.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_reg  <= '0;
      idx_reg    <= '0;
      seg_reg    <= SEG_0;
      dig_en_reg <= DIGITS'(1);
    end else begin
      presc_reg  <= presc_next;
      idx_reg    <= idx_next;
      seg_reg    <= digit_code[idx_next];
      dig_en_reg <= DIGITS'(1) << idx_next;
    end
  end

  assign busy   = (state_reg != ST_IDLE);
  assign seg    = seg_reg;
  assign dig_en = dig_en_reg;

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display: scan timing, conversion latency,
// blanking, over-range, ignored loads and reset behaviour.
module tb_score_display;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] score8;
  logic       load8;
  logic [9:0] score10;
  logic       load10;

  logic       busy0, busy1, busy2, busy3;
  logic [6:0] seg0, seg1, seg2, seg3;
  logic [2:0] dig_en0, dig_en1, dig_en2;
  logic [1:0] dig_en3;

  logic [6:0] seen0 [3];
  logic [6:0] seen1 [3];
  logic [6:0] seen2 [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  score_display #(.SCORE_W(8), .DIGITS(3), .SCAN_DIV(8), .BLANK_LZ(1)) u0 (
    .clk(clk), .rst(rst), .score(score8), .load(load8),
    .busy(busy0), .seg(seg0), .dig_en(dig_en0));

  score_display #(.SCORE_W(10), .DIGITS(3), .SCAN_DIV(4), .BLANK_LZ(1)) u1 (
    .clk(clk), .rst(rst), .score(score10), .load(load10),
    .busy(busy1), .seg(seg1), .dig_en(dig_en1));

  score_display #(.SCORE_W(10), .DIGITS(3), .SCAN_DIV(4), .BLANK_LZ(0)) u2 (
    .clk(clk), .rst(rst), .score(score10), .load(load10),
    .busy(busy2), .seg(seg2), .dig_en(dig_en2));

  score_display #(.SCORE_W(8), .DIGITS(2), .SCAN_DIV(4), .BLANK_LZ(1)) u3 (
    .clk(clk), .rst(rst), .score(score8), .load(1'b0),
    .busy(busy3), .seg(seg3), .dig_en(dig_en3));

  // Latest segment pattern observed for each digit position.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (dig_en0[d]) seen0[d] <= seg0;
      if (dig_en1[d]) seen1[d] <= seg1;
      if (dig_en2[d]) seen2[d] <= seg2;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Counts busy cycles from the current negedge until busy drops (bounded).
  task automatic wait_idle(input int which, output int n);
    n = 0;
    while (((which == 0) ? busy0 : busy1) && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (n >= 40) check_val("busy_timeout", 32'(n), 32'd0);
  endtask

  task automatic pulse_load8(input logic [7:0] v);
    score8 = v;
    load8  = 1'b1;
    @(negedge clk);
    load8  = 1'b0;
  endtask

  task automatic pulse_load10(input logic [9:0] v);
    score10 = v;
    load10  = 1'b1;
    @(negedge clk);
    load10  = 1'b0;
  endtask

  task automatic check_disp0(input string tag, input logic [6:0] e0,
                             input logic [6:0] e1, input logic [6:0] e2);
    check_val({tag, "_u"}, 32'(seen0[0]), 32'(e0));
    check_val({tag, "_t"}, 32'(seen0[1]), 32'(e1));
    check_val({tag, "_h"}, 32'(seen0[2]), 32'(e2));
    $display("[TB] u0 %s digits u/t/h = %h %h %h", tag, seen0[0], seen0[1], seen0[2]);
  endtask

  task automatic check_disp12(input string tag, input logic [6:0] a0,
                              input logic [6:0] a1, input logic [6:0] a2,
                              input logic [6:0] b0, input logic [6:0] b1,
                              input logic [6:0] b2);
    check_val({tag, "_blz_u"}, 32'(seen1[0]), 32'(a0));
    check_val({tag, "_blz_t"}, 32'(seen1[1]), 32'(a1));
    check_val({tag, "_blz_h"}, 32'(seen1[2]), 32'(a2));
    check_val({tag, "_all_u"}, 32'(seen2[0]), 32'(b0));
    check_val({tag, "_all_t"}, 32'(seen2[1]), 32'(b1));
    check_val({tag, "_all_h"}, 32'(seen2[2]), 32'(b2));
    $display("[TB] u1/u2 %s blz=%h %h %h all=%h %h %h", tag,
             seen1[0], seen1[1], seen1[2], seen2[0], seen2[1], seen2[2]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; load8 = 1'b0; load10 = 1'b0; score8 = '0; score10 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state and idle scan of three/two digit instances.
    check_val("rst_busy", 32'(busy0), 32'd0);
    check_val("rst_dig_en", 32'(dig_en0), 32'h1);
    check_val("rst_seg", 32'(seg0), 32'h3F);
    for (int t = 0; t < 24; t++) begin
      check_val("scan_dig_en0", 32'(dig_en0), 32'(3'b001 << ((t / 8) % 3)));
      check_val("scan_seg0", 32'(seg0), (t < 8) ? 32'h3F : 32'h00);
      check_val("scan_dig_en3", 32'(dig_en3), 32'(2'b01 << ((t / 4) % 2)));
      check_val("scan_seg3", 32'(seg3), (((t / 4) % 2) == 0) ? 32'h3F : 32'h00);
      check_val("scan_busy0", 32'(busy0), 32'd0);
      @(negedge clk);
    end
    $display("[TB] idle scan checked over 24 cycles");

    // 255 -> 2 5 5
    pulse_load8(8'd255);
    wait_idle(0, n);
    check_val("busy_len_255", 32'(n), 32'd8);
    repeat (27) @(negedge clk);
    check_disp0("d255", 7'h76, 7'h76, 7'h6D);

    // 100: interior zero must not be blanked
    pulse_load8(8'd100);
    wait_idle(0, n);
    check_val("busy_len_100", 32'(n), 32'd8);
    repeat (27) @(negedge clk);
    check_disp0("d100", 7'h3F, 7'h3F, 7'h03);

    // 0: single units zero
    pulse_load8(8'd0);
    wait_idle(0, n);
    repeat (27) @(negedge clk);
    check_disp0("d0", 7'h3F, 7'h00, 7'h00);

    // 42 followed by 99 while busy: 99 must be dropped
    pulse_load8(8'd42);
    score8 = 8'd99;
    repeat (2) @(negedge clk);
    load8 = 1'b1;
    repeat (3) @(negedge clk);
    load8 = 1'b0;
    wait_idle(0, n);
    check_val("busy_tail_42", 32'(n), 32'd3);
    @(negedge clk);
    check_val("busy_after_42", 32'(busy0), 32'd0);
    repeat (27) @(negedge clk);
    check_disp0("d42", 7'h6D, 7'h53, 7'h00);

    // Over-range and blanking mode comparison on the 10-bit instances
    pulse_load10(10'd1000);
    wait_idle(1, n);
    check_val("busy_len_1000", 32'(n), 32'd10);
    repeat (16) @(negedge clk);
    check_disp12("d1000", 7'h78, 7'h78, 7'h78, 7'h78, 7'h78, 7'h78);

    pulse_load10(10'd7);
    wait_idle(1, n);
    repeat (16) @(negedge clk);
    check_disp12("d7", 7'h23, 7'h00, 7'h00, 7'h23, 7'h3F, 7'h3F);

    // Reset during conversion
    pulse_load8(8'd200);
    repeat (2) @(negedge clk);
    check_val("busy_mid_200", 32'(busy0), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("abort_busy", 32'(busy0), 32'd0);
    check_val("abort_dig_en", 32'(dig_en0), 32'h1);
    check_val("abort_seg", 32'(seg0), 32'h3F);
    @(negedge clk);
    check_val("abort_busy_hold", 32'(busy0), 32'd0);
    repeat (27) @(negedge clk);
    check_disp0("abort", 7'h3F, 7'h00, 7'h00);

    // Reset wins over a simultaneous load
    score8 = 8'd77; load8 = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; load8 = 1'b0;
    check_val("rst_over_load", 32'(busy0), 32'd0);
    repeat (27) @(negedge clk);
    check_disp0("rst_load", 7'h3F, 7'h00, 7'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/score_display.md
# score_display

Sequential successor to the two-digit score segment lookup: converts a parameter-width binary score to BCD with a serial double-dabble engine and drives a time-multiplexed, DIGITS-wide seven-segment display with leading-zero blanking and an over-range indication. It sits between the game score counter and the board display pins, one instance per player.

## Interface
- SCORE_W, 8: width of the binary score input (≥ 4).
- DIGITS, 3: number of displayed decimal digits (1–8).
- SCAN_DIV, 1024: clocks each digit stays enabled (≥ 2).
- BLANK_LZ, 1: 1 = blank leading zeros; 0 = show all digits.
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- score  in  SCORE_W  binary value, sampled on an accepted load.
- load  in  1  conversion request pulse.
- busy  out  1  conversion in progress; load ignored while high.
- seg  out  7  active-high segment pattern for the enabled digit.
- dig_en  out  DIGITS  one-hot active-high digit enable; bit 0 = units.

## Operation
- Digit codes (seg[6:0], hex): 0→3F, 1→03, 2→6D, 3→67, 4→53, 5→76, 6→7E, 7→23, 8→7F, 9→77; blank→00; error→78.
- Accepted load (load=1, busy=0): capture score into shift register, clear BCD accumulator, busy←1.
- Conversion: SCORE_W iterations; each iteration adds 3 to every BCD nibble ≥ 5, then shifts {bcd, bin} left one bit. Accumulator holds DIGITS+1 nibbles so over-range is detectable.
- Completion: displayed-value register updated atomically in one cycle; never shows a partial conversion. Over-range flag set if any nibble above DIGITS-1 is non-zero.
- Over-range: every digit shows 78 regardless of BLANK_LZ.
- Blanking (BLANK_LZ=1): digit k>0 shows 00 if it and all higher digits are zero; digit 0 is never blanked (score 0 shows a single "0").
- Scan: prescaler counts 0..SCAN_DIV-1; on terminal count the digit index advances, wrapping DIGITS-1→0. seg and dig_en are registered together and always refer to the same digit.
- load while busy: ignored, no queuing.

## Timing
- Reset values: busy=0, dig_en=1 (units), seg=3F, displayed value 0, over-range 0, prescaler 0, conversion state idle.
- Load accepted at edge N: busy=1 from N+1 through N+SCORE_W; busy=0 and displayed value updated at edge N+SCORE_W+1. Next load is accepted at that edge.
- seg reflects a new displayed value no later than the first clock after the update; dig_en timing is unaffected by loads.
- Each dig_en bit stays high for exactly SCAN_DIV clocks; full refresh period DIGITS×SCAN_DIV.
- rst mid-conversion: conversion aborted, busy=0 next cycle, display returns to "0".
- rst has priority over load in the same cycle.

## Structure
- Package score_display_pkg: segment code constants (SEG_0..SEG_9, SEG_BLANK=7'h00, SEG_ERR=7'h78) and the BCD nibble type.
- Sub-module seg7_digit_lut: combinational 4-bit BCD → 7-bit code; inputs 10–15 map to SEG_ERR.
- Top contains the double-dabble FSM (IDLE, SHIFT with iteration counter, DONE), displayed-value/over-range register, prescaler, digit index, blanking logic and output registers.

## Test plan
- Reset then idle 3×SCAN_DIV clocks → dig_en cycles 001,010,100; seg = 3F,00,00; busy stays 0.
- Load 255 (SCORE_W=8, DIGITS=3) → busy high 8 cycles; digits units/tens/hundreds show 76,76,6D.
- SCORE_W=10, DIGITS=3, load 1000 → all three digits show 78; then load 7 → 23,00,00; with BLANK_LZ=0 → 23,3F,3F.
- Load 42, then load 99 while busy → 99 ignored; display shows 6D,53,00 after 9 cycles.
- Load 200, assert rst at busy cycle 3 → busy=0 next cycle, display 3F,00,00, dig_en=001.
- SCAN_DIV=4, DIGITS=2 → each dig_en bit high exactly 4 clocks, index wraps 1→0, seg changes on the same edge as dig_en.
